// File: rtl/rgb_fader_pkg.sv
// Shared types and defaults for the RGB PWM fader: channel state encoding,
// default widths/intervals and small helpers.
package rgb_fader_pkg;

  localparam int unsigned PWM_BITS_DEF      = 8;
  localparam int unsigned STEP_INTERVAL_DEF = 7843;
  localparam int unsigned MAX_DUTY_DEF      = 255;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RISING  = 2'd1,
    ON      = 2'd2,
    FALLING = 2'd3
  } fade_state_t;

  // An interval of 1 still needs a 1-bit timer that wraps every cycle.
  function automatic int unsigned timer_width(input int unsigned interval);
    return (interval > 1) ? $clog2(interval) : 1;
  endfunction

  function automatic logic is_ramping(input fade_state_t s);
    return (s == RISING) || (s == FALLING);
  endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One LED channel: fade FSM with saturating duty ramp, period-aligned shadow
// duty, PWM compare and registered pin with selectable polarity.
module pwm_fade_channel
  import rgb_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned MAX_DUTY   = MAX_DUTY_DEF,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tgt_i,
  input  logic                step_tick_i,
  input  logic                period_start_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output fade_state_t         state_o
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

  fade_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                led_q, led_d;

  // A target change wins over a coincident tick: only the state moves.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    shadow_d = period_start_i ? duty_q : shadow_q;
    led_d    = (pwm_cnt_i < shadow_q) ^ ACTIVE_LOW;
    case (state_q)
      OFF: begin
        duty_d = '0;
        if (tgt_i) state_d = RISING;
      end
      RISING: begin
        if (!tgt_i) begin
          state_d = FALLING;
        end else if (step_tick_i) begin
          if (duty_q >= DUTY_MAX - DUTY_ONE) begin
            duty_d  = DUTY_MAX;
            state_d = ON;
          end else begin
            duty_d = duty_q + DUTY_ONE;
          end
        end
      end
      ON: begin
        duty_d = DUTY_MAX;
        if (!tgt_i) state_d = FALLING;
      end
      FALLING: begin
        if (tgt_i) begin
          state_d = RISING;
        end else if (step_tick_i) begin
          if (duty_q <= DUTY_ONE) begin
            duty_d  = '0;
            state_d = OFF;
          end else begin
            duty_d = duty_q - DUTY_ONE;
          end
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= OFF;
      duty_q   <= '0;
      shadow_q <= '0;
      led_q    <= ACTIVE_LOW;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign led_o   = led_q;
  assign state_o = state_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED fader: turns on/off colour targets into PWM crossfades. Owns the
// input registers, step timer, shared PWM counter and the busy flag.
module rgb_pwm_fader
  import rgb_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS      = PWM_BITS_DEF,
  parameter int unsigned STEP_INTERVAL = STEP_INTERVAL_DEF,
  parameter int unsigned MAX_DUTY      = MAX_DUTY_DEF,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic led_r,
  output logic led_g,
  output logic led_b,
  output logic busy
);

  localparam int unsigned         TMR_W    = timer_width(STEP_INTERVAL);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(STEP_INTERVAL - 1);

  logic [2:0]          tgt_q, tgt_d;
  logic [TMR_W-1:0]    step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                busy_q, busy_d;
  logic                step_tick_c, period_start_c;
  fade_state_t         state_r, state_g, state_b;

  always_comb begin
    tgt_d          = {blue_in, green_in, red_in};
    step_tick_c    = (step_cnt_q == TMR_LAST);
    step_cnt_d     = step_tick_c ? '0 : step_cnt_q + 1'b1;
    pwm_cnt_d      = pwm_cnt_q + 1'b1;
    period_start_c = (pwm_cnt_q == '0);
    busy_d         = is_ramping(state_r) | is_ramping(state_g) | is_ramping(state_b);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q      <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      tgt_q      <= tgt_d;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      busy_q     <= busy_d;
    end
  end

  pwm_fade_channel #(
    .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY), .ACTIVE_LOW(ACTIVE_LOW)
  ) u_ch_r (
    .clk(clk), .rst_n(rst_n), .tgt_i(tgt_q[0]), .step_tick_i(step_tick_c),
    .period_start_i(period_start_c), .pwm_cnt_i(pwm_cnt_q),
    .led_o(led_r), .state_o(state_r)
  );

  pwm_fade_channel #(
    .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY), .ACTIVE_LOW(ACTIVE_LOW)
  ) u_ch_g (
    .clk(clk), .rst_n(rst_n), .tgt_i(tgt_q[1]), .step_tick_i(step_tick_c),
    .period_start_i(period_start_c), .pwm_cnt_i(pwm_cnt_q),
    .led_o(led_g), .state_o(state_g)
  );

  pwm_fade_channel #(
    .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY), .ACTIVE_LOW(ACTIVE_LOW)
  ) u_ch_b (
    .clk(clk), .rst_n(rst_n), .tgt_i(tgt_q[2]), .step_tick_i(step_tick_c),
    .period_start_i(period_start_c), .pwm_cnt_i(pwm_cnt_q),
    .led_o(led_b), .state_o(state_b)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader (4-bit PWM, tick every 4 cycles, max 15,
// active-low pins); expected values queued at drive time, popped at sampling.
module tb_rgb_pwm_fader;
  import rgb_fader_pkg::*;

  logic clk = 1'b0;
  logic rst_n, red_in, green_in, blue_in;
  logic led_r, led_g, led_b, busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int tcyc;
  int n, cr, cg, cb;
  bit seen;

  rgb_pwm_fader #(
    .PWM_BITS(4), .STEP_INTERVAL(4), .MAX_DUTY(15), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .red_in(red_in), .green_in(green_in),
    .blue_in(blue_in), .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference free-running cycle count; equals the PWM counter modulo 16.
  always @(posedge clk) begin
    if (!rst_n) tcyc <= 0;
    else        tcyc <= tcyc + 1;
  end

  task automatic chk(input string tag, input int obs);
    int e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  task automatic wait_rem(input int m, input int r);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((tcyc % m) != r && guard < 64);
    if ((tcyc % m) != r) begin
      n_checks++;
      n_errors++;
      $error("FAIL align observed=%0d expected=%0d", tcyc % m, r);
    end
  endtask

  task automatic count_lit(input int cycles, output int lr, output int lg, output int lb);
    lr = 0; lg = 0; lb = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (led_r === 1'b0) lr++;
      if (led_g === 1'b0) lg++;
      if (led_b === 1'b0) lb++;
    end
  endtask

  initial begin
    rst_n = 1'b0; red_in = 1'b1; green_in = 1'b1; blue_in = 1'b1;

    // Reset held with all targets on: pins unlit, busy low.
    repeat (5) begin
      @(negedge clk);
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
      chk("rst_led_r", led_r); chk("rst_led_g", led_g);
      chk("rst_led_b", led_b); chk("rst_busy", busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(1); exp_q.push_back(0);
    chk("post_rst_led_r", led_r); chk("post_rst_busy", busy);
    repeat (2) @(negedge clk);
    exp_q.push_back(1);
    chk("busy_after_release", busy);

    // Reset mid-ramp.
    repeat (10) @(negedge clk);
    rst_n = 1'b0; red_in = 1'b1; green_in = 1'b0; blue_in = 1'b1;
    @(negedge clk);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(int'(OFF));
    chk("midramp_rst_led_r", led_r); chk("midramp_rst_busy", busy);
    chk("midramp_rst_duty_r", dut.u_ch_r.duty_q);
    chk("midramp_rst_state_r", int'(dut.u_ch_r.state_q));
    @(negedge clk);
    rst_n = 1'b1;

    // Full rise of red and blue from 0.
    n = 0; seen = 1'b0;
    while (n < 120) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) seen = 1'b1;
      else if (seen) break;
    end
    exp_q.push_back(1);
    chk("rise_busy_drop_in_56_66", int'(seen && busy === 1'b0 && n >= 56 && n <= 66));
    exp_q.push_back(15); exp_q.push_back(int'(ON)); exp_q.push_back(int'(ON));
    chk("rise_duty_r", dut.u_ch_r.duty_q);
    chk("rise_state_r", int'(dut.u_ch_r.state_q));
    chk("rise_state_b", int'(dut.u_ch_b.state_q));
    repeat (20) @(negedge clk);
    count_lit(16, cr, cg, cb);
    exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(15);
    chk("on_lit_r", cr); chk("on_lit_g", cg); chk("on_lit_b", cb);

    // Full fall of red, one duty step per tick.
    wait_rem(4, 0);
    red_in = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      exp_q.push_back(i);
      wait_rem(4, 0);
      chk("fall_duty_r", dut.u_ch_r.duty_q);
    end
    exp_q.push_back(int'(OFF));
    chk("fall_state_r", int'(dut.u_ch_r.state_q));
    @(negedge clk);
    exp_q.push_back(0);
    chk("fall_busy", busy);
    repeat (20) @(negedge clk);
    count_lit(32, cr, cg, cb);
    exp_q.push_back(0); exp_q.push_back(30);
    chk("off_lit_r", cr); chk("off_lit_b", cb);

    // Reversal at duty 6.
    wait_rem(4, 0);
    red_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back(i);
      wait_rem(4, 0);
      chk("rev_up_duty_r", dut.u_ch_r.duty_q);
      if (i == 1) begin
        exp_q.push_back(int'(RISING));
        chk("rev_state_rising", int'(dut.u_ch_r.state_q));
      end
    end
    red_in = 1'b0;
    wait_rem(4, 2);
    exp_q.push_back(int'(FALLING)); exp_q.push_back(6);
    chk("rev_state_falling", int'(dut.u_ch_r.state_q));
    chk("rev_turn_duty_r", dut.u_ch_r.duty_q);
    for (int i = 5; i >= 0; i--) begin
      exp_q.push_back(i);
      wait_rem(4, 0);
      chk("rev_down_duty_r", dut.u_ch_r.duty_q);
    end
    exp_q.push_back(int'(OFF));
    chk("rev_state_off", int'(dut.u_ch_r.state_q));

    // Shadow duty: pulse width changes only at period boundaries.
    wait_rem(16, 0);
    red_in = 1'b1;
    wait_rem(16, 1);
    exp_q.push_back(0); exp_q.push_back(15);
    exp_q.push_back(4); exp_q.push_back(15);
    exp_q.push_back(8); exp_q.push_back(15);
    for (int w = 0; w < 3; w++) begin
      count_lit(16, cr, cg, cb);
      chk("shadow_lit_r", cr);
      chk("shadow_lit_b", cb);
    end

    // Green target drop coincident with a step tick.
    wait_rem(4, 0);
    green_in = 1'b1;
    for (int i = 0; i < 3; i++) wait_rem(4, 0);
    exp_q.push_back(3);
    chk("sim_green_up_duty", dut.u_ch_g.duty_q);
    wait_rem(4, 2);
    green_in = 1'b0;
    wait_rem(4, 0);
    exp_q.push_back(int'(FALLING)); exp_q.push_back(3);
    chk("sim_green_state", int'(dut.u_ch_g.state_q));
    chk("sim_green_hold_duty", dut.u_ch_g.duty_q);
    wait_rem(4, 0);
    exp_q.push_back(2); exp_q.push_back(int'(ON));
    chk("sim_green_next_tick_duty", dut.u_ch_g.duty_q);
    chk("sim_blue_state", int'(dut.u_ch_b.state_q));
    count_lit(16, cr, cg, cb);
    exp_q.push_back(15);
    chk("sim_blue_lit", cb);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
